// File: rtl/dl_mem_pkg.sv
// Shared types for the download/core SDRAM arbiter: FSM states, address widths
// and the download FIFO entry layout.
package dl_mem_pkg;

    localparam int ADDR_W  = 25;
    localparam int WADDR_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } dl_entry_t;

    // Even byte address lands in the low byte lane of the 16-bit word.
    function automatic logic [1:0] byte_en(input logic addr_lsb);
        return addr_lsb ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dl_mem_arbiter_if.sv
// 16-bit SDRAM request port: the arbiter is the master, the memory controller the slave.
interface dl_mem_arbiter_if;
    import dl_mem_pkg::*;

    logic               mem_req;
    logic               mem_we;
    logic [WADDR_W-1:0] mem_addr;
    logic [15:0]        mem_din;
    logic [1:0]         mem_be;
    logic               mem_ack;
    logic [15:0]        mem_dout;

    modport master (
        output mem_req, mem_we, mem_addr, mem_din, mem_be,
        input  mem_ack, mem_dout
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_din, mem_be,
        output mem_ack, mem_dout
    );

endinterface

// File: rtl/dl_byte_fifo.sv
// Download byte FIFO with flop storage; a push into a full FIFO is discarded.
module dl_byte_fifo
    import dl_mem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  dl_entry_t push_data,
    input  logic      pop,
    output dl_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    dl_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_en;
    logic               pop_en;

    // Full is taken from the count before any same-cycle pop.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dl_mem_arbiter.sv
// Shares one 16-bit SDRAM port between the SPI ROM download stream (priority)
// and single-word core reads; holds the core in reset around a download.
//
// state | meaning
// IDLE  | no request outstanding; picks a download byte first, else a core read
// WR    | download byte write in flight, waiting for mem_ack
// RD    | core read in flight, waiting for mem_ack
module dl_mem_arbiter
    import dl_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int POST_RST   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               downloading,
    input  logic               dl_wr,
    input  logic [ADDR_W-1:0]  dl_addr,
    input  logic [7:0]         dl_data,
    output logic               dl_overflow,
    output logic               core_reset,
    input  logic               core_rd,
    input  logic [WADDR_W-1:0] core_addr,
    output logic [15:0]        core_dout,
    output logic               core_ready,
    dl_mem_arbiter_if.master   mem
);

    arb_state_t         state;
    arb_state_t         state_nxt;

    dl_entry_t          push_entry;
    dl_entry_t          fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;

    logic               rd_pend;
    logic [WADDR_W-1:0] rd_addr;
    logic               rd_accept;
    logic               rd_avail;
    logic [WADDR_W-1:0] rd_addr_sel;

    logic               issue_wr;
    logic               issue_rd;
    logic               ack_wr;
    logic               ack_rd;

    logic               mem_req_q;
    logic               mem_we_q;
    logic [WADDR_W-1:0] mem_addr_q;
    logic [15:0]        mem_din_q;
    logic [1:0]         mem_be_q;

    logic               dl_q;
    logic               hold_core;
    logic [7:0]         post_cnt;

    assign push_entry = '{addr: dl_addr, data: dl_data};

    dl_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (dl_wr),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A fresh core_rd can be issued in its own cycle, giving the one-cycle read latency.
    assign rd_accept   = core_rd && !core_reset && !rd_pend;
    assign rd_avail    = rd_pend || rd_accept;
    assign rd_addr_sel = rd_pend ? rd_addr : core_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        ack_wr    = 1'b0;
        ack_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    issue_wr  = 1'b1;
                    state_nxt = WR;
                end else if (rd_avail) begin
                    issue_rd  = 1'b1;
                    state_nxt = RD;
                end
            end
            WR: begin
                if (mem.mem_ack) begin
                    ack_wr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                if (mem.mem_ack) begin
                    ack_rd    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            core_dout  <= '0;
            core_ready <= 1'b0;
        end else begin
            core_ready <= 1'b0;
            if (issue_wr) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b1;
                mem_addr_q <= fifo_head.addr[ADDR_W-1:1];
                mem_din_q  <= {fifo_head.data, fifo_head.data};
                mem_be_q   <= byte_en(fifo_head.addr[0]);
            end else if (issue_rd) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= rd_addr_sel;
                mem_be_q   <= 2'b11;
            end else if (ack_wr || ack_rd) begin
                mem_req_q  <= 1'b0;
            end
            if (ack_rd) begin
                core_dout  <= mem.mem_dout;
                core_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
        end else if (ack_rd) begin
            rd_pend <= 1'b0;
        end else if (rd_accept) begin
            rd_pend <= 1'b1;
            rd_addr <= core_addr;
        end
    end

    // A drop in the same cycle as a download restart still reports the overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q        <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (dl_wr && fifo_full)
                dl_overflow <= 1'b1;
            else if (downloading && !dl_q)
                dl_overflow <= 1'b0;
        end
    end

    assign hold_core = downloading || !fifo_empty || (state == WR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            post_cnt <= 8'(POST_RST);
        else if (hold_core)
            post_cnt <= 8'(POST_RST);
        else if (post_cnt != 8'd0)
            post_cnt <= post_cnt - 8'd1;
    end

    assign core_reset = hold_core || (post_cnt != 8'd0);

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;
    assign mem.mem_be   = mem_be_q;

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Scoreboard bench for dl_mem_arbiter: expected SDRAM requests and core read data
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_dl_mem_arbiter;

    localparam int FIFO_DEPTH = 8;
    localparam int POST_RST   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_overflow;
    logic        core_reset;
    logic        core_rd = 1'b0;
    logic [23:0] core_addr = '0;
    logic [15:0] core_dout;
    logic        core_ready;

    dl_mem_arbiter_if mif();

    always #5 clk = ~clk;

    dl_mem_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .POST_RST   (POST_RST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .downloading (downloading),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_overflow (dl_overflow),
        .core_reset  (core_reset),
        .core_rd     (core_rd),
        .core_addr   (core_addr),
        .core_dout   (core_dout),
        .core_ready  (core_ready),
        .mem         (mif)
    );

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
        logic [15:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] rd_exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    bit          ack_hold = 1'b0;
    bit          busy = 1'b0;
    int          wcnt = 0;
    txn_t        cur;
    logic [23:0] cur_addr = '0;
    logic [18:0] cur_ctl = '0;
    int          req_cyc = 0, ack_cyc = 0, ready_cyc = 0, ready_cnt = 0;
    int          wr_cyc = 0, rd_cyc = 0;
    logic        rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory controller model: captures each request, checks it, acks after a delay.
    initial begin
        mif.mem_ack  = 1'b0;
        mif.mem_dout = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            if (reset) begin
                busy = 1'b0;
                continue;
            end
            if (busy) begin
                check_eq("req_held", mif.mem_req, 1);
                check_eq("addr_stable", mif.mem_addr, cur_addr);
                check_eq("ctl_stable", {mif.mem_we, mif.mem_be, mif.mem_din}, cur_ctl);
            end else if (mif.mem_req) begin
                busy     = 1'b1;
                wcnt     = 1;
                req_cyc  = cyc;
                cur_addr = mif.mem_addr;
                cur_ctl  = {mif.mem_we, mif.mem_be, mif.mem_din};
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_req", mif.mem_req, 0);
                    cur.rdata = '0;
                end else begin
                    cur = exp_q.pop_front();
                    check_eq("mem_we", mif.mem_we, cur.we);
                    check_eq("mem_addr", mif.mem_addr, cur.addr);
                    check_eq("mem_be", mif.mem_be, cur.be);
                    if (cur.we) check_eq("mem_din", mif.mem_din, cur.din);
                end
            end
            if (busy && !ack_hold) begin
                if (wcnt == 0) begin
                    mif.mem_ack  = 1'b1;
                    mif.mem_dout = cur.rdata;
                    ack_cyc      = cyc;
                    busy         = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rdy_prev = 1'b0;
                continue;
            end
            if (rdy_prev) check_eq("ready_width", core_ready, 0);
            if (core_ready && !rdy_prev) begin
                ready_cnt++;
                ready_cyc = cyc;
                if (rd_exp_q.size() == 0) check_eq("unexpected_ready", core_ready, 0);
                else check_eq("core_dout", core_dout, rd_exp_q.pop_front());
            end
            rdy_prev = core_ready;
        end
    end

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input bit keep);
        @(posedge clk); #1;
        dl_wr = 1'b1; dl_addr = a; dl_data = d; wr_cyc = cyc;
        if (keep)
            exp_q.push_back('{we: 1'b1, addr: a[24:1], din: {d, d},
                              be: (a[0] ? 2'b10 : 2'b01), rdata: 16'h0});
        @(posedge clk); #1;
        dl_wr = 1'b0;
    endtask

    task automatic core_read(input logic [23:0] a, input logic [15:0] rdata, input bit keep);
        @(posedge clk); #1;
        core_rd = 1'b1; core_addr = a; rd_cyc = cyc;
        if (keep) begin
            exp_q.push_back('{we: 1'b0, addr: a, din: 16'h0, be: 2'b11, rdata: rdata});
            rd_exp_q.push_back(rdata);
        end
        @(posedge clk); #1;
        core_rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rd_exp_q.size() != 0 || busy || mif.mem_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({"drain_", tag}, exp_q.size() + rd_exp_q.size() + int'(busy), 0);
    endtask

    task automatic wait_core_free(input string tag, input int budget);
        int n = 0;
        while (core_reset && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({"core_free_", tag}, core_reset, 0);
    endtask

    initial begin
        int  hold_cnt;
        bit  saw_req;
        int  r0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req", mif.mem_req, 0);
        check_eq("rst_mem_we", mif.mem_we, 0);
        check_eq("rst_mem_addr", mif.mem_addr, 0);
        check_eq("rst_mem_din", mif.mem_din, 0);
        check_eq("rst_mem_be", mif.mem_be, 0);
        check_eq("rst_core_dout", core_dout, 0);
        check_eq("rst_core_ready", core_ready, 0);
        check_eq("rst_overflow", dl_overflow, 0);
        check_eq("rst_core_reset", core_reset, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single byte download
        downloading = 1'b1;
        repeat (2) @(posedge clk);
        dl_byte(25'h000005, 8'hA7, 1);
        wait_idle("t1", 50);
        check_eq("wr_latency", req_cyc - wr_cyc, 2);
        check_eq("t1_addr", cur_addr, 24'h000002);
        check_eq("t1_ctl", cur_ctl, {1'b1, 2'b10, 16'hA7A7});

        // Burst with the arbiter blocked: 8 fit, the last two drop
        ack_hold = 1'b1;
        dl_byte(25'h0000F0, 8'h55, 1);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++)
            dl_byte(25'h000200 + 25'(i), 8'h30 + 8'(i), i < FIFO_DEPTH);
        @(negedge clk);
        check_eq("overflow_set", dl_overflow, 1);
        ack_hold = 1'b0;
        wait_idle("t2", 300);
        check_eq("overflow_sticky", dl_overflow, 1);
        @(posedge clk); #1;
        downloading = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("overflow_hold", dl_overflow, 1);
        @(posedge clk); #1;
        downloading = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("overflow_clr", dl_overflow, 0);

        // Download bytes queued behind an in-flight read go before the next read
        @(posedge clk); #1;
        downloading = 1'b0;
        wait_core_free("t3", 60);
        ack_hold = 1'b1;
        core_read(24'h000ABC, 16'h1111, 1);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        downloading = 1'b1;
        dl_byte(25'h000301, 8'h9A, 1);
        dl_byte(25'h000302, 8'h6B, 1);
        @(posedge clk); #1;
        downloading = 1'b0;
        @(negedge clk);
        check_eq("t3_hold", core_reset, 1);
        core_read(24'h000DEF, 16'h2222, 0);
        ack_hold = 1'b0;
        wait_idle("t3a", 100);
        wait_core_free("t3b", 60);
        core_read(24'h000DEF, 16'h2222, 1);
        wait_idle("t3c", 50);

        // Plain core read
        core_read(24'h001234, 16'hBEEF, 1);
        wait_idle("t4", 50);
        check_eq("rd_latency", req_cyc - rd_cyc, 1);
        check_eq("ready_latency", ready_cyc - ack_cyc, 1);
        check_eq("t4_addr", cur_addr, 24'h001234);
        check_eq("t4_be", cur_ctl[17:16], 2'b11);

        // Post-download reset hold; a read during the hold is ignored
        @(posedge clk); #1;
        downloading = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        downloading = 1'b0;
        hold_cnt = 0;
        saw_req  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mif.mem_req) saw_req = 1'b1;
            if (!core_reset) break;
            hold_cnt++;
            if (hold_cnt == 5) begin
                core_rd   = 1'b1;
                core_addr = 24'h000777;
            end else begin
                core_rd = 1'b0;
            end
        end
        core_rd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mif.mem_req) saw_req = 1'b1;
        end
        check_eq("hold_cycles", hold_cnt, POST_RST);
        check_eq("hold_no_req", saw_req, 0);

        // Asynchronous reset while a write is outstanding
        ack_hold = 1'b1;
        @(posedge clk); #1;
        downloading = 1'b1;
        dl_byte(25'h000401, 8'hC3, 1);
        dl_byte(25'h000402, 8'hC4, 0);
        dl_byte(25'h000403, 8'hC5, 0);
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        check_eq("t6_in_wr", mif.mem_req & mif.mem_we, 1);
        r0 = ready_cnt;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_eq("t6_req_drop", mif.mem_req, 0);
        check_eq("t6_core_reset", core_reset, 1);
        exp_q.delete();
        ack_hold    = 1'b0;
        downloading = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        saw_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mif.mem_req) saw_req = 1'b1;
        end
        check_eq("t6_fifo_empty", saw_req, 0);
        check_eq("t6_no_ready", ready_cnt - r0, 0);
        check_eq("t6_core_reset_held", core_reset, 1);
        check_eq("t6_overflow", dl_overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
